pc_fetch_sequencer: RTL and testbench

- Owns the architectural PC register and sequences instruction fetch against a ready-handshaked instruction memory.
- Resolves next-PC from four sources: sequential PC+4, JALR, JAL, and conditional branch (BEQ/BNE on ALU zero).
- Handles pipeline stall, redirect flush and misaligned-target fault.
- Sits between the IF stage and the EX-stage redirect outputs, and replaces the free-running PC register plus a combinational PC mux.

---
 rtl/pc_fetch_sequencer.sv | 152 +++++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_sequencer.sv
// PC register and instruction-fetch sequencer: sequential advance, JALR/JAL/branch
// redirects, stall hold, and sticky faults for misaligned targets or memory timeout.
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned IMEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        jalr_valid,
    input  logic [31:0] jalr_target,
    input  logic        jal_valid,
    input  logic [31:0] jal_target,
    input  logic        branch,
    input  logic        b_type,
    input  logic [31:0] alu_res,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        if_valid,
    output logic        redirect,
    output logic        fault,
    output logic [1:0]  fault_cause
);

    // Memory handshake: a fetch completes in any cycle where imem_req and
    // imem_ready are both high; imem_addr may move freely while imem_ready is low.

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } state_t;

    localparam logic [1:0]  CAUSE_NONE     = 2'b00;
    localparam logic [1:0]  CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0]  CAUSE_TIMEOUT  = 2'b10;
    localparam bit          TIMEOUT_EN     = (IMEM_TIMEOUT != 0);
    localparam logic [15:0] WAIT_LAST      = 16'(IMEM_TIMEOUT - 1);

    state_t      state;
    state_t      state_next;
    logic [31:0] pc_next;
    logic [15:0] wait_cnt;
    logic [15:0] wait_cnt_next;
    logic        fault_next;
    logic [1:0]  cause_next;
    logic        branch_taken;
    logic        redir_req;
    logic [31:0] redir_target;
    logic        active;

    assign branch_taken = branch & (b_type ? (alu_res == 32'd0) : (alu_res != 32'd0));
    assign active       = (state == FETCH) || (state == HOLD);
    assign pc_plus4     = pc + 32'd4;
    assign imem_addr    = pc;

    always_comb begin
        redir_req    = 1'b0;
        redir_target = 32'd0;
        if (jalr_valid) begin
            redir_req    = 1'b1;
            redir_target = jalr_target;
        end else if (jal_valid) begin
            redir_req    = 1'b1;
            redir_target = jal_target;
        end else if (branch_taken) begin
            redir_req    = 1'b1;
            redir_target = branch_target;
        end
    end

    always_comb begin
        state_next    = state;
        pc_next       = pc;
        wait_cnt_next = wait_cnt;
        fault_next    = fault;
        cause_next    = fault_cause;
        imem_req      = 1'b0;
        if_valid      = 1'b0;
        redirect      = 1'b0;

        case (state)
            BOOT: state_next = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    if_valid      = 1'b1;
                    wait_cnt_next = 16'd0;
                    if (stall) state_next = HOLD;
                    else       pc_next    = pc_plus4;
                end else if (TIMEOUT_EN) begin
                    if (wait_cnt == WAIT_LAST) begin
                        state_next = FAULT;
                        fault_next = 1'b1;
                        cause_next = CAUSE_TIMEOUT;
                    end else begin
                        wait_cnt_next = wait_cnt + 16'd1;
                    end
                end
            end
            HOLD: begin
                if_valid = 1'b1;
                if (!stall) begin
                    pc_next    = pc_plus4;
                    state_next = FETCH;
                end
            end
            default: ;
        endcase

        // A redirect beats stall, sequential advance and a coincident timeout;
        // whatever was fetched this cycle is wrong-path and is never delivered.
        if (active && redir_req) begin
            if_valid = 1'b0;
            if (redir_target[1:0] == 2'b00) begin
                redirect      = 1'b1;
                pc_next       = redir_target;
                state_next    = FETCH;
                wait_cnt_next = 16'd0;
                fault_next    = 1'b0;
                cause_next    = CAUSE_NONE;
            end else begin
                pc_next    = pc;
                state_next = FAULT;
                fault_next = 1'b1;
                cause_next = CAUSE_MISALIGN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            wait_cnt    <= 16'd0;
            fault       <= 1'b0;
            fault_cause <= CAUSE_NONE;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            wait_cnt    <= wait_cnt_next;
            fault       <= fault_next;
            fault_cause <= cause_next;
        end
    end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: scenario tasks with inline checks plus a queue of
// expected delivered-instruction PCs, consumed whenever IF/ID accepts an instruction.
module tb_pc_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        jalr_valid = 1'b0;
    logic [31:0] jalr_target = 32'd0;
    logic        jal_valid = 1'b0;
    logic [31:0] jal_target = 32'd0;
    logic        branch = 1'b0;
    logic        b_type = 1'b0;
    logic [31:0] alu_res = 32'd0;
    logic [31:0] branch_target = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b1;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        if_valid;
    logic        redirect;
    logic        fault;
    logic [1:0]  fault_cause;

    int          n_cmp = 0;
    int          n_mis = 0;
    logic        sb_on = 1'b0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    pc_fetch_sequencer #(
        .RESET_PC    (32'h0000_0100),
        .IMEM_TIMEOUT(4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .jalr_valid   (jalr_valid),
        .jalr_target  (jalr_target),
        .jal_valid    (jal_valid),
        .jal_target   (jal_target),
        .branch       (branch),
        .b_type       (b_type),
        .alu_res      (alu_res),
        .branch_target(branch_target),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .if_valid     (if_valid),
        .redirect     (redirect),
        .fault        (fault),
        .fault_cause  (fault_cause)
    );

    // Every instruction handed to IF/ID (if_valid && !stall) must match the queue head.
    task automatic sb_monitor();
        logic [31:0] exp_pc;
        forever begin
            @(negedge clk);
            if (sb_on && rst_n && if_valid && !stall) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    $display("FAIL sb_underflow: delivered pc=%h, none expected", pc);
                    n_mis++;
                end else begin
                    exp_pc = exp_q.pop_front();
                    if (pc !== exp_pc) begin
                        $display("FAIL sb_pc: got %h exp %h", pc, exp_pc);
                        n_mis++;
                    end
                end
            end
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ex();
        jalr_valid = 1'b0;
        jal_valid  = 1'b0;
        branch     = 1'b0;
        b_type     = 1'b0;
        alu_res    = 32'd0;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        stall      = 1'b0;
        imem_ready = 1'b1;
        clear_ex();
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        n_cmp++; if (pc !== 32'h100) begin $display("FAIL rst_pc: got %h exp 00000100", pc); n_mis++; end
        n_cmp++; if (imem_req !== 1'b0) begin $display("FAIL rst_req: got %b exp 0", imem_req); n_mis++; end
        n_cmp++; if (if_valid !== 1'b0) begin $display("FAIL rst_if_valid: got %b exp 0", if_valid); n_mis++; end
        n_cmp++; if (redirect !== 1'b0) begin $display("FAIL rst_redirect: got %b exp 0", redirect); n_mis++; end
        n_cmp++; if (fault !== 1'b0) begin $display("FAIL rst_fault: got %b exp 0", fault); n_mis++; end
        n_cmp++; if (fault_cause !== 2'b00) begin $display("FAIL rst_cause: got %b exp 00", fault_cause); n_mis++; end
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin
            $display("FAIL boot_idle: got req=%b if_valid=%b exp 0/0", imem_req, if_valid); n_mis++;
        end
        next_cycle();
        sb_on = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back(32'h100 + 32'(4 * i));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (pc !== 32'h100 + 32'(4 * i) || imem_addr !== pc) begin
                $display("FAIL seq_pc: got pc=%h addr=%h exp %h", pc, imem_addr, 32'h100 + 32'(4 * i)); n_mis++;
            end
            n_cmp++; if (if_valid !== 1'b1 || imem_req !== 1'b1) begin
                $display("FAIL seq_valid: got if_valid=%b req=%b exp 1/1", if_valid, imem_req); n_mis++;
            end
            next_cycle();
        end
        sb_on = 1'b0;
        n_cmp++; if (exp_q.size() != 0) begin $display("FAIL seq_left: got %0d exp 0", exp_q.size()); n_mis++; end
        exp_q.delete();
    endtask

    task automatic test_stall();
        jal_valid  = 1'b1;
        jal_target = 32'h20;
        @(negedge clk);
        n_cmp++; if (redirect !== 1'b1 || if_valid !== 1'b0) begin
            $display("FAIL jal_redirect: got redirect=%b if_valid=%b exp 1/0", redirect, if_valid); n_mis++;
        end
        next_cycle();
        clear_ex();
        sb_on = 1'b1;
        exp_q.push_back(32'h20);
        exp_q.push_back(32'h24);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (pc !== 32'h20 || if_valid !== 1'b1) begin
                $display("FAIL stall_hold: got pc=%h if_valid=%b exp 00000020/1", pc, if_valid); n_mis++;
            end
            if (i > 0) begin
                n_cmp++; if (imem_req !== 1'b0) begin $display("FAIL hold_req: got %b exp 0", imem_req); n_mis++; end
            end
            next_cycle();
        end
        stall = 1'b0;
        @(negedge clk);
        n_cmp++; if (pc !== 32'h20 || imem_req !== 1'b0) begin
            $display("FAIL hold_release: got pc=%h req=%b exp 00000020/0", pc, imem_req); n_mis++;
        end
        next_cycle();
        @(negedge clk);
        n_cmp++; if (pc !== 32'h24 || imem_req !== 1'b1) begin
            $display("FAIL stall_after: got pc=%h req=%b exp 00000024/1", pc, imem_req); n_mis++;
        end
        next_cycle();
        sb_on = 1'b0;
        n_cmp++; if (exp_q.size() != 0) begin $display("FAIL stall_left: got %0d exp 0", exp_q.size()); n_mis++; end
        exp_q.delete();
    endtask

    task automatic test_branch();
        jal_valid = 1'b1; jal_target = 32'h40;
        next_cycle(); clear_ex();
        branch = 1'b1; b_type = 1'b1; alu_res = 32'd0; branch_target = 32'h400;
        @(negedge clk);
        n_cmp++; if (redirect !== 1'b1 || if_valid !== 1'b0) begin
            $display("FAIL beq_redirect: got redirect=%b if_valid=%b exp 1/0", redirect, if_valid); n_mis++;
        end
        next_cycle(); clear_ex();
        @(negedge clk);
        n_cmp++; if (pc !== 32'h400 || redirect !== 1'b0) begin
            $display("FAIL beq_pc: got pc=%h redirect=%b exp 00000400/0", pc, redirect); n_mis++;
        end
        next_cycle();
        jal_valid = 1'b1; jal_target = 32'h40;
        next_cycle(); clear_ex();
        branch = 1'b1; b_type = 1'b0; alu_res = 32'd0; branch_target = 32'h400;
        @(negedge clk);
        n_cmp++; if (redirect !== 1'b0 || if_valid !== 1'b1) begin
            $display("FAIL bne_no_redirect: got redirect=%b if_valid=%b exp 0/1", redirect, if_valid); n_mis++;
        end
        next_cycle(); clear_ex();
        @(negedge clk);
        n_cmp++; if (pc !== 32'h44) begin $display("FAIL bne_pc: got %h exp 00000044", pc); n_mis++; end
        next_cycle();
    endtask

    task automatic test_branch_random();
        logic [31:0] exp_pc;
        logic [31:0] tgt;
        logic        taken;
        jal_valid = 1'b1; jal_target = 32'h200;
        next_cycle(); clear_ex();
        exp_pc = 32'h200;
        sb_on = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tgt           = 32'h1000 + 32'($urandom_range(0, 255)) * 32'd4;
            branch        = 1'($urandom_range(0, 1));
            b_type        = 1'($urandom_range(0, 1));
            alu_res       = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'($urandom_range(1, 1000));
            branch_target = tgt;
            taken = branch && (b_type ? (alu_res == 32'd0) : (alu_res != 32'd0));
            if (!taken) exp_q.push_back(exp_pc);
            @(negedge clk);
            n_cmp++; if (redirect !== taken) begin
                $display("FAIL rnd_redirect: got %b exp %b (b_type=%b alu=%h)", redirect, taken, b_type, alu_res); n_mis++;
            end
            next_cycle();
            exp_pc = taken ? tgt : exp_pc + 32'd4;
        end
        clear_ex();
        sb_on = 1'b0;
        n_cmp++; if (pc !== exp_pc) begin $display("FAIL rnd_pc: got %h exp %h", pc, exp_pc); n_mis++; end
        n_cmp++; if (exp_q.size() != 0) begin $display("FAIL rnd_left: got %0d exp 0", exp_q.size()); n_mis++; end
        exp_q.delete();
    endtask

    task automatic test_priority();
        jalr_valid = 1'b1; jalr_target = 32'h800;
        jal_valid = 1'b1; jal_target = 32'h900;
        branch = 1'b1; b_type = 1'b1; alu_res = 32'd0; branch_target = 32'hA00;
        @(negedge clk);
        n_cmp++; if (redirect !== 1'b1) begin $display("FAIL prio_redirect: got %b exp 1", redirect); n_mis++; end
        next_cycle(); clear_ex();
        @(negedge clk);
        n_cmp++; if (pc !== 32'h800) begin $display("FAIL prio_jalr: got %h exp 00000800", pc); n_mis++; end
        next_cycle();
        jal_valid = 1'b1; jal_target = 32'h900;
        branch = 1'b1; b_type = 1'b1; alu_res = 32'd0; branch_target = 32'hA00;
        next_cycle(); clear_ex();
        @(negedge clk);
        n_cmp++; if (pc !== 32'h900) begin $display("FAIL prio_jal: got %h exp 00000900", pc); n_mis++; end
        next_cycle();
        jalr_valid = 1'b1; jalr_target = 32'h700;
        jal_valid = 1'b1; jal_target = 32'h402;
        next_cycle(); clear_ex();
        @(negedge clk);
        n_cmp++; if (pc !== 32'h700 || fault !== 1'b0) begin
            $display("FAIL prio_masked: got pc=%h fault=%b exp 00000700/0", pc, fault); n_mis++;
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        jal_valid = 1'b1; jal_target = 32'h300;
        next_cycle(); clear_ex();
        jalr_valid = 1'b1; jalr_target = 32'h500;
        @(negedge clk);
        n_cmp++; if (redirect !== 1'b1 || pc !== 32'h300) begin
            $display("FAIL b2b_second: got redirect=%b pc=%h exp 1/00000300", redirect, pc); n_mis++;
        end
        next_cycle(); clear_ex();
        @(negedge clk);
        n_cmp++; if (pc !== 32'h500 || redirect !== 1'b0) begin
            $display("FAIL b2b_pc: got pc=%h redirect=%b exp 00000500/0", pc, redirect); n_mis++;
        end
        next_cycle();
        stall = 1'b1;
        next_cycle();
        jal_valid = 1'b1; jal_target = 32'h700;
        @(negedge clk);
        n_cmp++; if (redirect !== 1'b1 || if_valid !== 1'b0 || imem_req !== 1'b0) begin
            $display("FAIL hold_redirect: got redirect=%b if_valid=%b req=%b exp 1/0/0", redirect, if_valid, imem_req); n_mis++;
        end
        next_cycle(); clear_ex();
        @(negedge clk);
        n_cmp++; if (pc !== 32'h700 || imem_req !== 1'b1) begin
            $display("FAIL hold_redirect_pc: got pc=%h req=%b exp 00000700/1", pc, imem_req); n_mis++;
        end
        stall = 1'b0;
        next_cycle();
    endtask

    task automatic test_wrap();
        jal_valid = 1'b1; jal_target = 32'hFFFF_FFFC;
        next_cycle(); clear_ex();
        @(negedge clk);
        n_cmp++; if (imem_addr !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin
            $display("FAIL wrap_plus4: got addr=%h plus4=%h exp fffffffc/00000000", imem_addr, pc_plus4); n_mis++;
        end
        next_cycle();
        @(negedge clk);
        n_cmp++; if (pc !== 32'h0 || fault !== 1'b0) begin
            $display("FAIL wrap_pc: got pc=%h fault=%b exp 00000000/0", pc, fault); n_mis++;
        end
        next_cycle();
    endtask

    task automatic test_misaligned();
        do_reset();
        jal_valid = 1'b1; jal_target = 32'h402;
        @(negedge clk);
        n_cmp++; if (redirect !== 1'b0) begin $display("FAIL mis_no_redirect: got %b exp 0", redirect); n_mis++; end
        next_cycle(); clear_ex();
        @(negedge clk);
        n_cmp++; if (fault !== 1'b1 || fault_cause !== 2'b01) begin
            $display("FAIL mis_fault: got fault=%b cause=%b exp 1/01", fault, fault_cause); n_mis++;
        end
        n_cmp++; if (pc !== 32'h100) begin $display("FAIL mis_pc: got %h exp 00000100", pc); n_mis++; end
        next_cycle();
        jal_valid = 1'b1; jal_target = 32'h200; imem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (imem_req !== 1'b0 || if_valid !== 1'b0 || redirect !== 1'b0 || pc !== 32'h100 || fault !== 1'b1) begin
                $display("FAIL fault_sticky: got req=%b if_valid=%b redirect=%b pc=%h fault=%b exp 0/0/0/00000100/1",
                         imem_req, if_valid, redirect, pc, fault); n_mis++;
            end
            next_cycle();
        end
        clear_ex();
        rst_n = 1'b0;
        #1;
        n_cmp++; if (fault !== 1'b0 || fault_cause !== 2'b00) begin
            $display("FAIL fault_clear: got fault=%b cause=%b exp 0/00", fault, fault_cause); n_mis++;
        end
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_timeout();
        do_reset();
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (fault !== 1'b0 || imem_req !== 1'b1 || if_valid !== 1'b0) begin
                $display("FAIL wait_state: got fault=%b req=%b if_valid=%b exp 0/1/0", fault, imem_req, if_valid); n_mis++;
            end
            next_cycle();
        end
        imem_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (if_valid !== 1'b1 || pc !== 32'h100) begin
            $display("FAIL late_ready: got if_valid=%b pc=%h exp 1/00000100", if_valid, pc); n_mis++;
        end
        next_cycle();
        imem_ready = 1'b0;
        repeat (3) next_cycle();
        jal_valid = 1'b1; jal_target = 32'h600;
        @(negedge clk);
        n_cmp++; if (redirect !== 1'b1) begin $display("FAIL to_redirect_wins: got %b exp 1", redirect); n_mis++; end
        next_cycle(); clear_ex();
        @(negedge clk);
        n_cmp++; if (fault !== 1'b0 || pc !== 32'h600) begin
            $display("FAIL to_after_redirect: got fault=%b pc=%h exp 0/00000600", fault, pc); n_mis++;
        end
        for (int j = 0; j < 3; j++) begin
            next_cycle();
            @(negedge clk);
            n_cmp++; if (fault !== 1'b0) begin $display("FAIL to_early: got fault=%b exp 0 at wait %0d", fault, j + 2); n_mis++; end
        end
        next_cycle();
        @(negedge clk);
        n_cmp++; if (fault !== 1'b1 || fault_cause !== 2'b10 || imem_req !== 1'b0) begin
            $display("FAIL to_fault: got fault=%b cause=%b req=%b exp 1/10/0", fault, fault_cause, imem_req); n_mis++;
        end
        next_cycle();
        imem_ready = 1'b1;
    endtask

    initial begin
        fork
            sb_monitor();
        join_none
        test_reset();
        test_stall();
        test_branch();
        test_branch_random();
        test_priority();
        test_back_to_back();
        test_wrap();
        test_misaligned();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
